// File: rtl/a4092_pkg.sv
// Shared A4092 definitions: Zorro III master sequencer states, defaults and
// the DS_n byte-lane decode.
package a4092_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_DATA    = 3'd3,
        ST_TERM    = 3'd4,
        ST_ERR     = 3'd5,
        ST_RECOVER = 3'd6
    } z3m_state_t;

    localparam int Z3M_TIMEOUT = 255;
    localparam int Z3M_SETUP   = 1;

    // DS_n[3] is D31:24, so lane k lands on bit 3-k; reads always strobe all lanes.
    function automatic logic [3:0] lane_decode(input logic [1:0] siz,
                                               input logic [1:0] a,
                                               input logic       read);
        logic [3:0] ds;
        logic [2:0] cnt;
        logic [2:0] last;
        ds   = 4'b1111;
        cnt  = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
        last = {1'b0, a} + cnt - 3'd1;
        if (read) begin
            ds = 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) >= {1'b0, a} && 3'(k) <= last)
                    ds[3-k] = 1'b0;
            end
        end
        return ds;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous bus strobes; reset value selectable.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/z3_master_cycle.sv
// Zorro III bus-master cycle sequencer: turns a granted 53C710 access into
// FCS/DS strobes, buffer enables and STERM/BERR back to the NCR.
//
// state   | meaning
// IDLE    | waiting for grant + NCR address strobe
// SETUP   | address driven, FCS not yet asserted
// STROBE  | FCS asserted, data strobes still off
// DATA    | data strobes on, waiting for DTACK/BERR/timeout
// TERM    | STERM to NCR, read data latched
// ERR     | BERR to NCR
// RECOVER | bus released, waiting for DTACK and AS to negate
module z3_master_cycle
    import a4092_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = Z3M_TIMEOUT,
    parameter int SETUP_CYCLES   = Z3M_SETUP
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       bmaster,
    input  logic       ncr_as_n,
    input  logic       ncr_read,
    input  logic [1:0] ncr_siz,
    input  logic [1:0] ncr_a,
    input  logic       z_dtack_n,
    input  logic       z_berr_n,
    output logic       z_fcs_n,
    output logic [3:0] z_ds_n,
    output logic       z_read,
    output logic       addr_oe,
    output logic       data_oe,
    output logic       d_latch,
    output logic       ncr_sterm_n,
    output logic       ncr_berr_n,
    output logic       busy
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] TO_VAL     = CW'(TIMEOUT_CYCLES);
    localparam logic [1:0]    SETUP_LOAD = 2'(SETUP_CYCLES - 1);

    logic as_n_s, dtack_n_s, berr_n_s;

    sync2 #(.RST_VAL(1'b1)) u_sync_as    (.CLK(CLK), .RST(RST), .d(ncr_as_n),  .q(as_n_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_dtack (.CLK(CLK), .RST(RST), .d(z_dtack_n), .q(dtack_n_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_berr  (.CLK(CLK), .RST(RST), .d(z_berr_n),  .q(berr_n_s));

    z3m_state_t    state, state_nx;
    logic [1:0]    setup_cnt;
    logic [CW-1:0] to_cnt;
    logic          rd_q;
    logic [1:0]    siz_q, a_q;

    logic          start;
    logic          rd_nx;
    logic [1:0]    siz_nx, a_nx;
    logic [3:0]    lanes_nx;

    logic          fcs_nx, read_nx, aoe_nx, doe_nx, dl_nx, sterm_nx, berr_nx, busy_nx;
    logic [3:0]    ds_nx;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (bmaster && !as_n_s) state_nx = ST_SETUP;
            ST_SETUP:   if (setup_cnt == 2'd0) state_nx = ST_STROBE;
            ST_STROBE:  state_nx = ST_DATA;
            ST_DATA: begin
                if (!berr_n_s)
                    state_nx = ST_ERR;
                else if (!dtack_n_s)
                    state_nx = ST_TERM;
                else if (to_cnt >= TO_VAL)
                    state_nx = ST_ERR;
            end
            ST_TERM:    state_nx = ST_RECOVER;
            ST_ERR:     state_nx = ST_RECOVER;
            ST_RECOVER: if (dtack_n_s && as_n_s) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state, so the captured access must be
    // visible on the same edge that captures it.
    assign start    = (state == ST_IDLE) && (state_nx == ST_SETUP);
    assign rd_nx    = start ? ncr_read : rd_q;
    assign siz_nx   = start ? ncr_siz  : siz_q;
    assign a_nx     = start ? ncr_a    : a_q;
    assign lanes_nx = lane_decode(siz_nx, a_nx, rd_nx);

    always_comb begin
        fcs_nx   = 1'b1;
        ds_nx    = 4'b1111;
        read_nx  = 1'b1;
        aoe_nx   = 1'b0;
        doe_nx   = 1'b0;
        dl_nx    = 1'b0;
        sterm_nx = 1'b1;
        berr_nx  = 1'b1;
        busy_nx  = (state_nx != ST_IDLE);
        case (state_nx)
            ST_SETUP: begin
                aoe_nx  = 1'b1;
                read_nx = rd_nx;
            end
            ST_STROBE: begin
                aoe_nx  = 1'b1;
                read_nx = rd_nx;
                fcs_nx  = 1'b0;
            end
            ST_DATA: begin
                aoe_nx  = 1'b1;
                read_nx = rd_nx;
                fcs_nx  = 1'b0;
                ds_nx   = lanes_nx;
                doe_nx  = !rd_nx;
            end
            ST_TERM: begin
                aoe_nx   = 1'b1;
                read_nx  = rd_nx;
                fcs_nx   = 1'b0;
                ds_nx    = lanes_nx;
                doe_nx   = !rd_nx;
                dl_nx    = rd_nx;
                sterm_nx = 1'b0;
            end
            ST_ERR: begin
                aoe_nx  = 1'b1;
                read_nx = rd_nx;
                fcs_nx  = 1'b0;
                ds_nx   = lanes_nx;
                berr_nx = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            setup_cnt   <= 2'd0;
            to_cnt      <= '0;
            rd_q        <= 1'b1;
            siz_q       <= 2'b00;
            a_q         <= 2'b00;
            z_fcs_n     <= 1'b1;
            z_ds_n      <= 4'b1111;
            z_read      <= 1'b1;
            addr_oe     <= 1'b0;
            data_oe     <= 1'b0;
            d_latch     <= 1'b0;
            ncr_sterm_n <= 1'b1;
            ncr_berr_n  <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state <= state_nx;
            rd_q  <= rd_nx;
            siz_q <= siz_nx;
            a_q   <= a_nx;

            if (start)
                setup_cnt <= SETUP_LOAD;
            else if (state == ST_SETUP && setup_cnt != 2'd0)
                setup_cnt <= setup_cnt - 2'd1;

            if (state == ST_IDLE)
                to_cnt <= '0;
            else if ((state == ST_STROBE || state == ST_DATA) && to_cnt != '1)
                to_cnt <= to_cnt + CW'(1);

            z_fcs_n     <= fcs_nx;
            z_ds_n      <= ds_nx;
            z_read      <= read_nx;
            addr_oe     <= aoe_nx;
            data_oe     <= doe_nx;
            d_latch     <= dl_nx;
            ncr_sterm_n <= sterm_nx;
            ncr_berr_n  <= berr_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_z3_master_cycle.sv
// Randomized bench for z3_master_cycle against a transaction-level timing model.
module tb_z3_master_cycle;

    localparam int TO  = 16;
    localparam int SU  = 1;
    localparam int BIG = 1000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       bmaster;
    logic       ncr_as_n;
    logic       ncr_read;
    logic [1:0] ncr_siz;
    logic [1:0] ncr_a;
    logic       z_dtack_n;
    logic       z_berr_n;
    logic       z_fcs_n;
    logic [3:0] z_ds_n;
    logic       z_read;
    logic       addr_oe;
    logic       data_oe;
    logic       d_latch;
    logic       ncr_sterm_n;
    logic       ncr_berr_n;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] data_ds;
    int         sterm_cnt, berr_cnt, dlatch_cnt;

    z3_master_cycle #(.TIMEOUT_CYCLES(TO), .SETUP_CYCLES(SU)) dut (
        .CLK(CLK), .RST(RST), .bmaster(bmaster), .ncr_as_n(ncr_as_n),
        .ncr_read(ncr_read), .ncr_siz(ncr_siz), .ncr_a(ncr_a),
        .z_dtack_n(z_dtack_n), .z_berr_n(z_berr_n), .z_fcs_n(z_fcs_n),
        .z_ds_n(z_ds_n), .z_read(z_read), .addr_oe(addr_oe), .data_oe(data_oe),
        .d_latch(d_latch), .ncr_sterm_n(ncr_sterm_n), .ncr_berr_n(ncr_berr_n),
        .busy(busy)
    );

    always #20 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active byte lanes: first = A[1:0], length from SIZ, clipped at the top of the long.
    function automatic logic [3:0] exp_lanes(input logic rd, input logic [1:0] siz, input logic [1:0] a);
        int first, nbytes, last;
        logic [3:0] ds;
        if (rd) return 4'b0000;
        first  = int'(a);
        nbytes = (siz == 2'b00) ? 4 : int'(siz);
        last   = first + nbytes - 1;
        if (last > 3) last = 3;
        ds = 4'b1111;
        for (int k = first; k <= last; k++) ds[3-k] = 1'b0;
        return ds;
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_fcs"},   z_fcs_n, 1'b1);
        check_eq({pfx, "_ds"},    z_ds_n, 4'b1111);
        check_eq({pfx, "_read"},  z_read, 1'b1);
        check_eq({pfx, "_aoe"},   addr_oe, 1'b0);
        check_eq({pfx, "_doe"},   data_oe, 1'b0);
        check_eq({pfx, "_dl"},    d_latch, 1'b0);
        check_eq({pfx, "_sterm"}, ncr_sterm_n, 1'b1);
        check_eq({pfx, "_berr"},  ncr_berr_n, 1'b1);
        check_eq({pfx, "_busy"},  busy, 1'b0);
    endtask

    // dt_n / be_n: cycles after the FCS edge at which the target drives DTACK/BERR (-1 = never).
    task automatic run_txn(input logic rd, input logic [1:0] siz, input logic [1:0] a,
                           input int dt_n, input int be_n, input int bm_delay,
                           input bit drop_bm, input bit early_as);
        int t_d, t_b, t_to, tend, s0, f_edge, as_neg, neg_rel, idle_rel, last_i;
        bit is_err, dt_on, be_on;
        logic [3:0] lanes;
        lanes = exp_lanes(rd, siz, a);
        // bus event -> 2 sync flops -> state register
        t_d  = (dt_n >= 0) ? dt_n + 3 : BIG;
        t_b  = (be_n >= 0) ? be_n + 3 : BIG;
        t_to = TO + 1;
        tend = t_d;
        if (t_b < tend) tend = t_b;
        if (t_to < tend) tend = t_to;
        is_err   = (t_b == tend) || (t_d != tend);
        s0       = (bm_delay > 0 && bm_delay + 1 > 3) ? bm_delay + 1 : 3;
        f_edge   = s0 + SU;
        dt_on    = (dt_n >= 0) && (dt_n < tend);
        be_on    = (be_n >= 0) && (be_n < tend);
        as_neg   = early_as ? int'($urandom_range(tend - 1, 1)) : tend;
        neg_rel  = dt_on ? tend : as_neg;
        idle_rel = (tend + 2 > neg_rel + 3) ? tend + 2 : neg_rel + 3;
        last_i   = f_edge + idle_rel + 1;
        sterm_cnt = 0; berr_cnt = 0; dlatch_cnt = 0; data_ds = 4'bxxxx;

        @(posedge CLK); #1;
        ncr_read = rd; ncr_siz = siz; ncr_a = a; ncr_as_n = 1'b0;
        bmaster  = (bm_delay > 0) ? 1'b0 : 1'b1;

        for (int i = 1; i <= last_i; i++) begin
            int rel;
            @(posedge CLK); #1;
            rel = i - f_edge;
            if (!ncr_sterm_n) sterm_cnt++;
            if (!ncr_berr_n) berr_cnt++;
            if (d_latch) dlatch_cnt++;
            if (i < s0 || rel >= idle_rel) begin
                check_eq("idle_busy", busy, 1'b0);
                check_eq("idle_fcs", z_fcs_n, 1'b1);
                check_eq("idle_ds", z_ds_n, 4'b1111);
                check_eq("idle_aoe", addr_oe, 1'b0);
                check_eq("idle_doe", data_oe, 1'b0);
                check_eq("idle_sterm", ncr_sterm_n, 1'b1);
                check_eq("idle_berr", ncr_berr_n, 1'b1);
            end else if (rel > tend) begin
                check_eq("rec_busy", busy, 1'b1);
                check_eq("rec_fcs", z_fcs_n, 1'b1);
                check_eq("rec_ds", z_ds_n, 4'b1111);
                check_eq("rec_aoe", addr_oe, 1'b0);
                check_eq("rec_doe", data_oe, 1'b0);
                check_eq("rec_dl", d_latch, 1'b0);
                check_eq("rec_sterm", ncr_sterm_n, 1'b1);
                check_eq("rec_berr", ncr_berr_n, 1'b1);
            end else begin
                check_eq("cyc_busy", busy, 1'b1);
                check_eq("cyc_aoe", addr_oe, 1'b1);
                if (rel == 1) data_ds = z_ds_n;
                if (rel < tend) begin
                    check_eq("cyc_read", z_read, rd);
                    check_eq("cyc_fcs", z_fcs_n, (rel < 0) ? 1'b1 : 1'b0);
                    check_eq("cyc_ds", z_ds_n, (rel < 1) ? 4'b1111 : lanes);
                    check_eq("cyc_doe", data_oe, (rel < 1) ? 1'b0 : !rd);
                    check_eq("cyc_dl", d_latch, 1'b0);
                    check_eq("cyc_sterm", ncr_sterm_n, 1'b1);
                    check_eq("cyc_berr", ncr_berr_n, 1'b1);
                end else if (is_err) begin
                    check_eq("err_berr", ncr_berr_n, 1'b0);
                    check_eq("err_sterm", ncr_sterm_n, 1'b1);
                    check_eq("err_dl", d_latch, 1'b0);
                end else begin
                    check_eq("term_sterm", ncr_sterm_n, 1'b0);
                    check_eq("term_berr", ncr_berr_n, 1'b1);
                    check_eq("term_dl", d_latch, rd);
                    check_eq("term_fcs", z_fcs_n, 1'b0);
                    check_eq("term_ds", z_ds_n, lanes);
                    check_eq("term_doe", data_oe, !rd);
                    check_eq("term_read", z_read, rd);
                end
            end
            if (bm_delay > 0 && i == bm_delay) bmaster = 1'b1;
            if (drop_bm && rel == 1) bmaster = 1'b0;
            if (dt_on && rel == dt_n) z_dtack_n = 1'b0;
            if (be_on && rel == be_n) z_berr_n = 1'b0;
            if (rel == as_neg) ncr_as_n = 1'b1;
            if (rel == tend) begin
                z_dtack_n = 1'b1; z_berr_n = 1'b1; ncr_as_n = 1'b1; bmaster = 1'b1;
            end
        end
        repeat (2) @(posedge CLK);
    endtask

    task automatic rst_in_data();
        @(posedge CLK); #1;
        ncr_read = 1'b0; ncr_siz = 2'b00; ncr_a = 2'b00; ncr_as_n = 1'b0; bmaster = 1'b1;
        repeat (6) @(posedge CLK);
        #3;
        check_eq("rstd_pre_busy", busy, 1'b1);
        check_eq("rstd_pre_ds", z_ds_n, 4'b0000);
        RST = 1'b1; ncr_as_n = 1'b1;
        #1;
        check_reset_vals("rstd");
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check_eq("rstd_post_busy", busy, 1'b0);
    endtask

    initial begin
        RST = 1'b1; bmaster = 1'b0; ncr_as_n = 1'b1; ncr_read = 1'b0;
        ncr_siz = 2'b00; ncr_a = 2'b00; z_dtack_n = 1'b1; z_berr_n = 1'b1;
        #5;
        check_reset_vals("rst");
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("rst_hold");
        RST = 1'b0; bmaster = 1'b1;
        repeat (3) @(posedge CLK);

        run_txn(1'b0, 2'b00, 2'b00, 4, -1, 0, 1'b0, 1'b0);
        check_eq("long_ds", data_ds, 4'b0000);
        check_eq("long_sterm_pulses", sterm_cnt, 1);

        run_txn(1'b0, 2'b01, 2'b10, 2, -1, 0, 1'b0, 1'b0);
        check_eq("byte_ds", data_ds, 4'b1101);

        run_txn(1'b0, 2'b10, 2'b11, 1, -1, 0, 1'b0, 1'b0);
        check_eq("word_clip_ds", data_ds, 4'b1110);

        run_txn(1'b0, 2'b10, 2'b01, 0, -1, 0, 1'b0, 1'b0);
        check_eq("word_mid_ds", data_ds, 4'b1001);

        run_txn(1'b1, 2'b10, 2'b00, 3, -1, 0, 1'b0, 1'b0);
        check_eq("read_ds", data_ds, 4'b0000);
        check_eq("read_dlatch_pulses", dlatch_cnt, 1);
        check_eq("read_sterm_pulses", sterm_cnt, 1);

        run_txn(1'b0, 2'b00, 2'b00, -1, -1, 0, 1'b0, 1'b0);
        check_eq("timeout_berr_pulses", berr_cnt, 1);
        check_eq("timeout_sterm_pulses", sterm_cnt, 0);

        run_txn(1'b0, 2'b00, 2'b00, 14, -1, 0, 1'b0, 1'b0);
        check_eq("dtack_vs_to_sterm", sterm_cnt, 1);
        check_eq("dtack_vs_to_berr", berr_cnt, 0);

        run_txn(1'b0, 2'b00, 2'b00, 15, -1, 0, 1'b0, 1'b0);
        check_eq("late_dtack_berr", berr_cnt, 1);

        run_txn(1'b0, 2'b00, 2'b00, 2, 2, 0, 1'b0, 1'b0);
        check_eq("berr_dtack_sterm", sterm_cnt, 0);
        check_eq("berr_dtack_berr", berr_cnt, 1);

        run_txn(1'b0, 2'b01, 2'b00, 3, -1, 6, 1'b0, 1'b0);
        check_eq("bm_late_sterm", sterm_cnt, 1);

        rst_in_data();

        for (int n = 0; n < 40; n++) begin
            int mode, dt, be, bmd;
            logic rd;
            logic [1:0] siz, a;
            rd   = 1'($urandom_range(1, 0));
            siz  = 2'($urandom_range(3, 0));
            a    = 2'($urandom_range(3, 0));
            mode = int'($urandom_range(5, 0));
            dt = -1; be = -1;
            case (mode)
                0, 1: dt = int'($urandom_range(16, 0));
                2:    be = int'($urandom_range(10, 0));
                3:    begin dt = int'($urandom_range(8, 0)); be = dt; end
                4:    begin be = int'($urandom_range(8, 0)); dt = be + int'($urandom_range(4, 1)); end
                default: ;
            endcase
            bmd = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 2)) : 0;
            run_txn(rd, siz, a, dt, be, bmd,
                    ($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/z3_master_cycle.md
# z3_master_cycle

Zorro III bus-master cycle sequencer for the A4092. Once the arbiter has granted the bus to the card (BMASTER high), it turns a 53C710 master access (AS_n, R/W, SIZ, A[1:0]) into a Zorro III cycle. It drives the cycle strobe, the data strobes, the buffer enables, and the cycle termination back to the NCR. It sits directly downstream of `zorro_master_arbiter` and drives the master-mode side of the buffer and strobe logic in the top level.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: CLK cycles with FCS asserted and no DTACK before the block forces a bus error.
- SETUP_CYCLES, 1: CLK cycles the address is driven before FCS_n falls (range 1–3).

Ports:
- CLK  in  1  25 MHz card clock; all state changes on rising edge.
- RST  in  1  Reset, asynchronous, active-high.
- bmaster  in  1  Bus granted to card (from arbiter).
- ncr_as_n  in  1  53C710 address strobe (async).
- ncr_read  in  1  53C710 R/W, 1 = read.
- ncr_siz  in  2  53C710 transfer size (00 = long, 01 = byte, 10 = word, 11 = 3-byte).
- ncr_a  in  2  53C710 A[1:0].
- z_dtack_n  in  1  Zorro DTACK_n (async).
- z_berr_n  in  1  Zorro BERR_n (async).
- z_fcs_n  out  1  Zorro FCS_n drive.
- z_ds_n  out  4  Zorro DS_n[3:0]; DS3 = D31:24.
- z_read  out  1  Zorro READ drive.
- addr_oe  out  1  Card→bus address buffer enable.
- data_oe  out  1  Card→bus data buffer enable (writes only).
- d_latch  out  1  One-cycle read-data latch pulse.
- ncr_sterm_n  out  1  Cycle termination to the NCR.
- ncr_berr_n  out  1  Bus error to the NCR.
- busy  out  1  High in every state except IDLE.

## Operation
- z_dtack_n, z_berr_n and ncr_as_n pass through 2-flop synchronizers (reset value 1). "DTACK", "BERR" and "AS" below mean the synchronized, asserted values.
- Start condition: IDLE, bmaster = 1 and AS asserted. On start, ncr_read, ncr_siz and ncr_a are captured; they are held for the rest of the cycle.
- Byte-lane decode:
  - start = ncr_a; count = 4 if siz = 00, otherwise siz.
  - Lanes k = start … min(3, start + count − 1) are active.
  - Lane k drives DS_n[3−k].
  - Example: siz = 10, a = 01 → DS_n = 1001.
  - Reads assert all four DS (0000), per Zorro III.
- States:
  - IDLE
  - SETUP: addr_oe = 1, z_read driven; lasts SETUP_CYCLES cycles.
  - STROBE: z_fcs_n = 0; lasts 1 cycle.
  - DATA: z_ds_n = lanes; data_oe = !read; waits here.
  - TERM: ncr_sterm_n = 0; d_latch = read; lasts 1 cycle.
  - ERR: ncr_berr_n = 0; lasts 1 cycle.
  - RECOVER: z_fcs_n = 1, z_ds_n = 1111, data_oe = 0, addr_oe = 0.
- Transitions:
  - IDLE → SETUP on the start condition.
  - SETUP → STROBE after SETUP_CYCLES.
  - STROBE → DATA.
  - DATA → ERR on BERR, else → TERM on DTACK, else → ERR when the timeout counter reaches TIMEOUT_CYCLES.
  - TERM → RECOVER.
  - ERR → RECOVER.
  - RECOVER → IDLE when DTACK and AS are both negated.
- In TERM, FCS and DS stay asserted. data_oe stays asserted through TERM for writes.
- Timeout counter: 8+ bits, width = clog2(TIMEOUT_CYCLES + 1). It clears in IDLE, increments in STROBE and DATA, and saturates; it never wraps.
- Simultaneous events in DATA:
  - BERR with DTACK → BERR wins (ERR).
  - DTACK with timeout → DTACK wins (TERM).
- bmaster is sampled only in IDLE. Losing the grant mid-cycle does not abort the cycle.
- A NCR AS negated before termination is ignored until RECOVER.

## Timing
- Reset values:
  - z_fcs_n = 1, z_ds_n = 1111, z_read = 1.
  - addr_oe = 0, data_oe = 0, d_latch = 0.
  - ncr_sterm_n = 1, ncr_berr_n = 1, busy = 0.
  - State = IDLE, counter = 0.
- RST asserted mid-cycle returns all outputs to their reset values immediately, asynchronously.
- All outputs are registered: they are decoded from the next state and change on the same edge as the state register.
- AS edge to busy: 3 cycles (2 for the synchronizer, 1 for the state register).
- Minimum cycle: AS sync (2) + SETUP (1) + STROBE (1) + DATA (≥1, plus 2 for DTACK synchronization) + TERM (1) + RECOVER (≥1).
- Back-to-back cycles: a new start is accepted only after passing through IDLE for at least one cycle.

## Structure
- Shared package `a4092_pkg`:
  - State enum `z3m_state_t`.
  - Function `lane_decode(siz, a, read)` returning a 4-bit DS_n value.
  - Default constants `Z3M_TIMEOUT` and `Z3M_SETUP`.
- Sub-module `sync2`: 2-flop synchronizer with reset value as a parameter. Instantiated three times.

## Test plan
- Long write: siz = 00, a = 00, DTACK 4 cycles after FCS.
  - DS_n = 0000 and data_oe = 1 from DATA through TERM.
  - One ncr_sterm_n pulse, then z_fcs_n high.
- Byte write: siz = 01, a = 10 → DS_n = 1101. Word write: siz = 10, a = 11 → DS_n = 1110 (clipped).
- Read: siz = 10.
  - DS_n = 0000, data_oe stays 0.
  - d_latch pulses in the same cycle as ncr_sterm_n.
- No DTACK, TIMEOUT_CYCLES = 16 → ncr_berr_n low exactly 1 cycle after the counter reaches 16; sterm never asserts.
- BERR and DTACK arrive in the same synchronized cycle → ERR path taken, ncr_sterm_n stays 1.
- RST asserted in DATA → all outputs at reset values before the next edge.
- AS low while bmaster = 0 → stays IDLE until bmaster rises.
